// File: rtl/decodeshift_chain.sv
// -----------------------------------------------------------------------------
// decodeshift_chain
//
// Purpose:
//   On a trigger, takes a snapshot of a packed counter value of NUM_DIGITS
//   nibbles plus per-digit decimal points. Each nibble is decoded to a
//   seven-segment byte {dp,g,f,e,d,c,b,a}. The bytes are then shifted
//   serially, most significant digit first and MSB (dp) first, into an
//   external chain of 74HC595-style shift registers. The block generates its
//   own shift clock and latch strobe.
//
// Parameters:
//   NUM_DIGITS  number of nibbles / display digits (1..8)
//   CLK_DIV     clk cycles per shiftClk half period (1..255)
//
// Optional build macro:
//   DECODESHIFT_LZ_BLANK_EN  when defined, digits above the highest nonzero
//                            nibble decode to a blank pattern. The dp bit is
//                            kept on blanked digits, and digit 0 is never
//                            blanked. Timing is the same in both builds.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   cnt_in    counter value, nibble 0 = least significant digit
//   dp_in     decimal-point enable per digit, captured with cnt_in
//   trigger   start request, level-sampled while idle
//   segOut    byte of the digit currently being shifted (held when idle)
//   shiftOut  serial data to the register chain
//   shiftClk  serial clock, external register samples on its rising edge
//   latchOut  storage-register strobe, active-high, CLK_DIV cycles long
//   busy      high from the LOAD cycle through the end of LATCH
//   done      one-cycle pulse on the edge where busy falls
// -----------------------------------------------------------------------------
module decodeshift_chain #(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_DIV    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] cnt_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    trigger,
  output logic [7:0]              segOut,
  output logic                    shiftOut,
  output logic                    shiftClk,
  output logic                    latchOut,
  output logic                    busy,
  output logic                    done
);

  localparam int                 DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0]   LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [7:0]         DIV_LAST   = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  state_t                  state_reg;
  logic [4*NUM_DIGITS-1:0] cnt_snap_reg;
  logic [NUM_DIGITS-1:0]   dp_snap_reg;
  logic [DIG_W-1:0]        digit_reg;
  logic [2:0]              bit_reg;
  logic [7:0]              div_reg;
  logic [7:0]              shift_data_reg;
  logic [7:0]              seg_reg;
  logic                    sclk_reg;
  logic                    latch_reg;
  logic                    busy_reg;
  logic                    done_reg;

  // Decoded byte for every digit of the snapshot.
  logic [7:0]              dig_byte [NUM_DIGITS];
  logic [DIG_W-1:0]        next_digit;
  logic [7:0]              load_byte;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef DECODESHIFT_LZ_BLANK_EN
  // upper_zero[i] is high when nibble i and every nibble above it are zero.
  // Bit NUM_DIGITS is the "nothing above the top digit" seed.
  logic [NUM_DIGITS:1] upper_zero;
  assign upper_zero[NUM_DIGITS] = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic [6:0] seg;
      assign nib = cnt_snap_reg[4*gi +: 4];
`ifdef DECODESHIFT_LZ_BLANK_EN
      if (gi == 0) begin : g_keep
        // The units digit always shows, so an all-zero value reads "0".
        assign seg = seg7(nib);
      end else begin : g_blank
        assign upper_zero[gi] = upper_zero[gi+1] & (nib == 4'h0);
        assign seg            = upper_zero[gi] ? 7'h00 : seg7(nib);
      end
`else
      assign seg = seg7(nib);
`endif
      assign dig_byte[gi] = {dp_snap_reg[gi], seg};
    end
  endgenerate

  // Byte to load next: the top digit when leaving LOAD, otherwise the digit
  // below the one that just finished.
  always_comb begin
    next_digit = digit_reg - 1'b1;
    load_byte  = (state_reg == ST_LOAD) ? dig_byte[LAST_DIGIT] : dig_byte[next_digit];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_snap_reg   <= '0;
      dp_snap_reg    <= '0;
      digit_reg      <= '0;
      bit_reg        <= '0;
      div_reg        <= '0;
      shift_data_reg <= '0;
      seg_reg        <= '0;
      sclk_reg       <= 1'b0;
      latch_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            cnt_snap_reg <= cnt_in;
            dp_snap_reg  <= dp_in;
            busy_reg     <= 1'b1;
            state_reg    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          digit_reg      <= LAST_DIGIT;
          bit_reg        <= 3'd7;
          shift_data_reg <= load_byte;
          seg_reg        <= load_byte;
          div_reg        <= '0;
          sclk_reg       <= 1'b0;
          state_reg      <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else begin
              // Falling edge: present the next bit, move to the next digit,
              // or finish and strobe the latch.
              sclk_reg <= 1'b0;
              if (bit_reg != 3'd0) begin
                bit_reg        <= bit_reg - 3'd1;
                shift_data_reg <= {shift_data_reg[6:0], 1'b0};
              end else if (digit_reg != '0) begin
                digit_reg      <= next_digit;
                bit_reg        <= 3'd7;
                shift_data_reg <= load_byte;
                seg_reg        <= load_byte;
              end else begin
                latch_reg <= 1'b1;
                state_reg <= ST_LATCH;
              end
            end
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end

        ST_LATCH: begin
          if (div_reg == DIV_LAST) begin
            div_reg   <= '0;
            latch_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign segOut   = seg_reg;
  assign shiftOut = shift_data_reg[7];
  assign shiftClk = sclk_reg;
  assign latchOut = latch_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_decodeshift_chain.sv
// -----------------------------------------------------------------------------
// tb_decodeshift_chain
//
// Directed bench for decodeshift_chain. One instance uses CLK_DIV=1 and
// another uses CLK_DIV=3, both with NUM_DIGITS=6. A table of {cnt, dp,
// expected bytes} records is run through the CLK_DIV=1 instance. Separate
// sequences cover the divider, a trigger and cnt_in change during a transfer,
// a reset during a transfer, and a trigger held high.
// -----------------------------------------------------------------------------
module tb_decodeshift_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] cnt;
  logic [5:0]  dp;
  logic        trig1, trig3;

  logic [7:0]  seg1, seg3;
  logic        so1, sc1, lat1, busy1, done1;
  logic        so3, sc3, lat3, busy3, done3;

  always #5 clk = ~clk;

  decodeshift_chain #(.NUM_DIGITS(6), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .cnt_in(cnt), .dp_in(dp), .trigger(trig1),
    .segOut(seg1), .shiftOut(so1), .shiftClk(sc1), .latchOut(lat1),
    .busy(busy1), .done(done1)
  );

  decodeshift_chain #(.NUM_DIGITS(6), .CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .cnt_in(cnt), .dp_in(dp), .trigger(trig3),
    .segOut(seg3), .shiftOut(so3), .shiftClk(sc3), .latchOut(lat3),
    .busy(busy3), .done(done3)
  );

  // Observation mux: sel selects which instance the tasks watch and drive.
  int          sel = 1;
  logic [7:0]  seg_o;
  logic        so_o, sc_o, lat_o, busy_o, done_o;

  always_comb begin
    if (sel == 3) begin
      seg_o = seg3; so_o = so3; sc_o = sc3; lat_o = lat3; busy_o = busy3; done_o = done3;
    end else begin
      seg_o = seg1; so_o = so1; sc_o = sc1; lat_o = lat1; busy_o = busy1; done_o = done1;
    end
  end

  int n_err = 0;
  int n_chk = 0;

  // Results of the last transfer.
  logic [47:0] got_all, seg_all;
  logic [7:0]  acc;
  int          nbits, busy_cyc, latch_cyc, latch_pulses, done_pulses, first_rise;
  int          hi_min, hi_max, lo_min, lo_max, so_bad, sc_bad;
  bit          timed_out;

  typedef struct {
    logic [23:0] cnt;
    logic [5:0]  dp;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_trig(input logic v);
    if (sel == 3) trig3 = v;
    else          trig1 = v;
  endtask

  // mode 0: one-cycle trigger
  // mode 1: second trigger plus cnt_in/dp_in change during SHIFT
  // mode 2: reset pulse during SHIFT, then watch for 200 cycles
  // mode 3: trigger left high (caller releases it)
  task automatic run_xfer(input int mode, input logic [23:0] c, input logic [5:0] d);
    int   k;
    int   hi_run, lo_run;
    bit   fall_seen;
    logic p_sc, p_so, p_lat;
    got_all = '0; seg_all = '0; acc = '0; nbits = 0;
    busy_cyc = 0; latch_cyc = 0; latch_pulses = 0; done_pulses = 0;
    first_rise = -1; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    so_bad = 0; sc_bad = 0; timed_out = 1'b1;
    hi_run = 0; lo_run = 0; fall_seen = 1'b0;
    @(negedge clk);
    cnt = c; dp = d;
    set_trig(1'b1);
    p_sc = sc_o; p_so = so_o; p_lat = lat_o;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0 && mode != 3) set_trig(1'b0);
      if (busy_o) busy_cyc++;
      if (lat_o) latch_cyc++;
      if (lat_o && !p_lat) latch_pulses++;
      if (sc_o && (lat_o || !busy_o)) sc_bad++;
      if (done_o) done_pulses++;
      if (sc_o) begin
        if (!p_sc) begin
          if (first_rise < 0) first_rise = k;
          if (fall_seen) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          hi_run = 0;
          acc = {acc[6:0], so_o};
          nbits++;
          if (nbits % 8 == 0) begin
            got_all = {got_all[39:0], acc};
            seg_all = {seg_all[39:0], seg_o};
          end
        end
        hi_run++;
      end else begin
        if (p_sc) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          fall_seen = 1'b1;
          lo_run = 0;
        end
        lo_run++;
      end
      // shiftOut may only move on the LOAD edge or a shiftClk falling edge.
      if (so_o !== p_so && !(p_sc && !sc_o) && k != 1 && !(mode == 2 && k >= 30)) so_bad++;
      if (mode == 1 && k == 20) begin
        set_trig(1'b1); cnt = 24'h111111; dp = 6'h3F;
      end
      if (mode == 1 && k == 21) set_trig(1'b0);
      if (mode == 2 && k == 30) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {seg_o, so_o, sc_o, lat_o, busy_o, done_o}, 64'h0);
      end
      if (mode == 2 && k == 31) rst_n = 1'b1;
      if (mode != 2 && done_o) begin timed_out = 1'b0; break; end
      if (mode == 2 && k == 200) begin timed_out = 1'b0; break; end
      p_sc = sc_o; p_so = so_o; p_lat = lat_o;
    end
    $display("xfer mode=%0d div=%0d cnt=%h dp=%b bytes=%h busy=%0d latch=%0d done=%0d",
             mode, sel, c, d, got_all, busy_cyc, latch_cyc, done_pulses);
  endtask

  task automatic check_xfer(input string tag, input logic [47:0] exp, input int div);
    check({tag, "_timeout"}, 64'(timed_out), 64'h0);
    check({tag, "_nbits"}, 64'(nbits), 64'd48);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got_all[47-8*i -: 8]), 64'(exp[47-8*i -: 8]));
    check({tag, "_segout_per_byte"}, 64'(seg_all), 64'(exp));
    check({tag, "_segout_hold"}, 64'(seg_o), 64'(exp[7:0]));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(1 + 6 * 16 * div + div));
    check({tag, "_latch_cycles"}, 64'(latch_cyc), 64'(div));
    check({tag, "_latch_pulses"}, 64'(latch_pulses), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_pulses), 64'd1);
    check({tag, "_first_rise"}, 64'(first_rise), 64'(1 + div));
    check({tag, "_sclk_idle_latch"}, 64'(sc_bad), 64'd0);
    check({tag, "_sdata_stable"}, 64'(so_bad), 64'd0);
    check({tag, "_half_periods"},
          {16'(hi_min), 16'(hi_max), 16'(lo_min), 16'(lo_max)},
          {16'(div), 16'(div), 16'(div), 16'(div)});
  endtask

  initial begin
    vecs[0] = '{24'h654321, 6'b000000, 48'h7D6D664F5B06};
    vecs[1] = '{24'h654321, 6'b000100, 48'h7D6D66CF5B06};
`ifdef DECODESHIFT_LZ_BLANK_EN
    vecs[2] = '{24'h00000A, 6'b000000, 48'h000000000077};
`else
    vecs[2] = '{24'h00000A, 6'b000000, 48'h3F3F3F3F3F77};
`endif
    vecs[3] = '{24'hFEDCBA, 6'b100001, 48'hF1795E397CF7};
    vecs[4] = '{24'h987000, 6'b000000, 48'h6F7F073F3F3F};
`ifdef DECODESHIFT_LZ_BLANK_EN
    vecs[5] = '{24'h000000, 6'b000010, 48'h00000000803F};
    vecs[6] = '{24'h001000, 6'b100000, 48'h8000063F3F3F};
`else
    vecs[5] = '{24'h000000, 6'b000010, 48'h3F3F3F3FBF3F};
    vecs[6] = '{24'h001000, 6'b100000, 48'hBF3F063F3F3F};
`endif

    rst_n = 1'b0; trig1 = 1'b0; trig3 = 1'b0; cnt = '0; dp = '0;
    repeat (3) @(negedge clk);
    check("reset_dut1", {seg1, so1, sc1, lat1, busy1, done1}, 64'h0);
    check("reset_dut3", {seg3, so3, sc3, lat3, busy3, done3}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transfers on the CLK_DIV=1 instance.
    sel = 1;
    for (int v = 0; v < 7; v++) begin
      run_xfer(0, vecs[v].cnt, vecs[v].dp);
      check_xfer($sformatf("v%0d", v), vecs[v].exp, 1);
      @(negedge clk);
      check($sformatf("v%0d_done_width", v), {62'h0, done_o, busy_o}, 64'h0);
    end

    // Divider of 3.
    sel = 3;
    run_xfer(0, 24'h654321, 6'b000000);
    check_xfer("div3", 48'h7D6D664F5B06, 3);
    @(negedge clk);
    check("div3_done_width", {62'h0, done_o, busy_o}, 64'h0);

    // Trigger and cnt_in change during SHIFT are ignored.
    sel = 1;
    run_xfer(1, 24'h654321, 6'b000000);
    check_xfer("ignore", 48'h7D6D664F5B06, 1);
    @(negedge clk);
    check("ignore_no_retrigger", {62'h0, done_o, busy_o}, 64'h0);

    // Reset during SHIFT aborts without latch or done, then a clean transfer.
    run_xfer(2, 24'h654321, 6'b000000);
    check("abort_latch_pulses", 64'(latch_pulses), 64'd0);
    check("abort_done_pulses", 64'(done_pulses), 64'd0);
    check("abort_idle", {62'h0, busy_o, sc_o}, 64'h0);
    run_xfer(0, 24'h654321, 6'b000100);
    check_xfer("after_reset", 48'h7D6D66CF5B06, 1);
    @(negedge clk);

    // Trigger held high re-arms right after done.
    run_xfer(3, 24'h987000, 6'b000000);
    check_xfer("held", 48'h6F7F073F3F3F, 1);
    @(negedge clk);
    check("held_rearm_busy", 64'(busy_o), 64'd1);
    set_trig(1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (done_o) begin seen = 1'b1; break; end
      end
      check("held_second_done", 64'(seen), 64'd1);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decodeshift_chain.md
# decodeshift_chain

Parametrised successor to the fixed-width seven-segment decode-and-shift block. On a trigger, it snapshots a packed hex/BCD counter value of `NUM_DIGITS` nibbles and decodes each nibble to a seven-segment pattern with a per-digit decimal point. It then shifts the patterns out serially, with generated shift clock and latch strobe, to an external chain of 8-bit shift registers (74HC595-style). It sits between the counter core and the display pins and adds a configurable shift-clock divider, busy/done handshake and optional leading-zero blanking.

## Interface
Parameters:
- `NUM_DIGITS`, default 6: number of nibbles/display digits, 1..8.
- `CLK_DIV`, default 1: `clk` cycles per shift-clock half period, 1..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cnt_in`  in  4*NUM_DIGITS  counter value; nibble 0 = least significant digit.
- `dp_in`  in  NUM_DIGITS  decimal-point enable per digit, captured with `cnt_in`.
- `trigger`  in  1  start request, level-sampled.
- `segOut`  out  8  pattern of the digit currently being shifted, `{dp,g,f,e,d,c,b,a}`, active-high.
- `shiftOut`  out  1  serial data to the register chain.
- `shiftClk`  out  1  serial clock; the external register samples on its rising edge.
- `latchOut`  out  1  storage-register strobe, active-high.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.

## Operation
- States: IDLE → LOAD → SHIFT → LATCH → IDLE.
- IDLE:
  - `trigger` sampled high moves the block to LOAD.
  - `cnt_in` and `dp_in` are registered into a snapshot on that same edge.
- LOAD (1 cycle):
  - The digit index is set to `NUM_DIGITS-1` and the bit index to 7.
  - The decoded byte is placed in the shift register.
- SHIFT:
  - Digits are sent most significant first; each byte is sent MSB (dp) first.
  - Each bit period is 2*CLK_DIV cycles: `shiftClk` is low for CLK_DIV cycles with `shiftOut` stable, then high for CLK_DIV cycles.
  - The next bit is presented on the falling edge.
  - After bit 0 of digit 0, the FSM enters LATCH.
- LATCH: `latchOut` is high for CLK_DIV cycles, then the FSM returns to IDLE.
- Decode (`{g..a}`):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - dp = the snapshot `dp_in` bit.
- `segOut` holds the byte of the digit being shifted and holds its last value in IDLE.
- `trigger` is ignored while `busy`; there is no queueing. `trigger` held high re-arms a new transfer immediately after `done`.
- `cnt_in` changes during a transfer have no effect; only the snapshot is used.

## Timing
- Reset values: `segOut`=00, `shiftOut`=0, `shiftClk`=0, `latchOut`=0, `busy`=0, `done`=0; the FSM is in IDLE and the snapshot is 0.
- Reset asserted mid-transfer aborts immediately to the reset values; no latch pulse is emitted.
- `busy` rises on the clock edge after `trigger` is sampled.
- `busy` length is 1 + NUM_DIGITS*16*CLK_DIV + CLK_DIV cycles.
- `done` pulses for one cycle on the edge where `busy` falls.
- The first `shiftClk` rising edge is CLK_DIV cycles after LOAD ends.
- `shiftOut` is stable for at least CLK_DIV cycles before and after each `shiftClk` rising edge.
- `shiftClk` is always low during LATCH and IDLE.

## Configuration
- Macro `DECODESHIFT_LZ_BLANK_EN`.
- Defined:
  - Every digit above the highest nonzero nibble of the snapshot decodes `{g..a}`=00.
  - dp is still honoured on blanked digits.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
- Undefined: all digits decode normally, including leading zeros.
- Timing is identical in both builds.

## Test plan
- NUM_DIGITS=6, CLK_DIV=1, `cnt_in`=24'h654321, `dp_in`=0, one-cycle `trigger`:
  - Serial bytes 7D, 6D, 66, 4F, 5B, 06, in that order.
  - `busy` high 98 cycles, one `latchOut` pulse of 1 cycle, then `done`.
- Same value with `dp_in`=6'b000100: the fourth byte is CF; all others are unchanged.
- `cnt_in`=24'h00000A:
  - With `DECODESHIFT_LZ_BLANK_EN` defined: 00,00,00,00,00,77.
  - Without the macro: 3F,3F,3F,3F,3F,77.
- CLK_DIV=3: each `shiftClk` half period is 3 cycles, `busy` is 1+288+3=292 cycles, and `latchOut` is 3 cycles.
- Second `trigger` pulse and a `cnt_in` change during SHIFT: both ignored; output bytes match the first snapshot and `done` pulses once.
- `reset` low for 1 cycle mid-SHIFT:
  - All outputs return to 0 asynchronously and no `latchOut`/`done` occurs.
  - The next `trigger` produces a full, correct transfer.
